// File: rtl/ps_pkg.sv
// ps_pkg: shared types and defaults for the PSfreq/PSamp pulse-line encoding.
// Used by the supply-side decoder and by the controller's output stage.
// Contents: FSM state type, code/counter widths, default timing, decode helpers.
package ps_pkg;

  localparam int CODE_W = 3;
  localparam int CNT_W  = 16;

  // Default line timing, in clocks.
  localparam int PS_STEP    = 16;
  localparam int PS_PERIOD  = 256;
  localparam int PS_TOL     = 8;
  localparam int PS_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } ps_state_t;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [CNT_W:0]    units_t;

  localparam cnt_t CNT_MAX = '1;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  // High time rounded to the nearest whole number of STEP units.
  function automatic units_t units(input cnt_t h, input int step);
    units_t s;
    s = {1'b0, h} + units_t'(step / 2);
    return s / units_t'(step);
  endfunction

endpackage

// File: rtl/ps_decoder_if.sv
// ps_decoder_if: the two pulse lines plus the decoded code/status outputs.
// master: line driver / result consumer (controller loop-back or bench).
// slave:  the decoder - samples PSfreq/PSamp, drives freq/amp/valids/update/lost.
interface ps_decoder_if;
  logic          PSfreq;
  logic          PSamp;
  ps_pkg::code_t freq;
  ps_pkg::code_t amp;
  logic          freqValid;
  logic          ampValid;
  logic          update;
  logic          lost;

  modport master (
    output PSfreq, PSamp,
    input  freq, amp, freqValid, ampValid, update, lost
  );

  modport slave (
    input  PSfreq, PSamp,
    output freq, amp, freqValid, ampValid, update, lost
  );
endinterface

// File: rtl/ps_channel.sv
// ps_channel: decodes one pulse line - 2-flop sync, edge detect, IDLE/HIGH/LOW
// frame FSM with saturating H/P counters, frame evaluation and loss timeout.
// Ports: clk, reset, line_i (async line); code_o/valid_o registered code state;
// wr_o (code written this cycle) and lost_d_o (next lost flag) feed top registers.
// Build option PSDEC_CONFIRM_EN: write a code only after two consecutive
// accepted frames decode the same value.
module ps_channel
  import ps_pkg::*;
#(
  parameter int STEP    = PS_STEP,
  parameter int PERIOD  = PS_PERIOD,
  parameter int TOL     = PS_TOL,
  parameter int TIMEOUT = PS_TIMEOUT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  line_i,
  output code_t code_o,
  output logic  valid_o,
  output logic  wr_o,
  output logic  lost_d_o
);

  localparam cnt_t P_LO = cnt_t'(PERIOD - TOL);
  localparam cnt_t P_HI = cnt_t'(PERIOD + TOL);
  localparam cnt_t TO_C = cnt_t'(TIMEOUT);

  logic      sync1_q, sync2_q, prev_q;
  ps_state_t state_q;
  cnt_t      h_q, p_q, sr_q;
  code_t     code_q;
  logic      valid_q, lost_q;
`ifdef PSDEC_CONFIRM_EN
  logic      pend_vld_q;
  code_t     pend_code_q;
`endif

  logic   rise, fall, close, accept, timeout, write, lost_d;
  cnt_t   p_inc;
  units_t n;
  code_t  new_code;

  always_comb begin
    rise  = sync2_q & ~prev_q;
    fall  = ~sync2_q & prev_q;
    // The closing rise cycle itself is part of the period.
    p_inc = sat_inc(p_q);
    n     = units(h_q, STEP);
    new_code = code_t'(n - units_t'(1));
    close = (state_q == ST_LOW) && rise;
    accept = close
          && (h_q != CNT_MAX) && (p_inc != CNT_MAX)
          && (n >= units_t'(1)) && (n <= units_t'(8))
          && (p_inc >= P_LO) && (p_inc <= P_HI);
    // A rise in the same cycle wins over the timeout.
    timeout = (state_q != ST_IDLE) && !rise && (sr_q >= TO_C);
`ifdef PSDEC_CONFIRM_EN
    write = accept && pend_vld_q && (pend_code_q == new_code);
`else
    write = accept;
`endif
    lost_d = lost_q;
    if (timeout)     lost_d = 1'b1;
    else if (accept) lost_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      state_q     <= ST_IDLE;
      h_q         <= '0;
      p_q         <= '0;
      sr_q        <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
`ifdef PSDEC_CONFIRM_EN
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
`endif
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      lost_q  <= lost_d;

      // Since-rise counter only runs once a frame has been opened, so an
      // idle line never reports loss.
      if (rise || timeout || state_q == ST_IDLE) sr_q <= '0;
      else                                       sr_q <= sat_inc(sr_q);

      if (write) begin
        code_q  <= new_code;
        valid_q <= 1'b1;
      end else if (timeout) begin
        valid_q <= 1'b0;
      end

`ifdef PSDEC_CONFIRM_EN
      if (timeout) begin
        pend_vld_q <= 1'b0;
      end else if (close) begin
        pend_vld_q  <= accept;
        pend_code_q <= new_code;
      end
`endif

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HIGH;
            h_q     <= '0;
            p_q     <= '0;
          end
        end
        ST_HIGH: begin
          if (timeout) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            p_q     <= '0;
          end else begin
            h_q <= sat_inc(h_q);
            p_q <= p_inc;
            if (fall) state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_q <= ST_HIGH;
            h_q     <= '0;
            p_q     <= '0;
          end else if (timeout) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            p_q     <= '0;
          end else begin
            p_q <= p_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign code_o   = code_q;
  assign valid_o  = valid_q;
  assign wr_o     = write;
  assign lost_d_o = lost_d;

endmodule

// File: rtl/ps_decoder.sv
// ps_decoder: recovers freq/amp codes from the PSfreq/PSamp pulse lines,
// checks frame timing and flags loss of either line. Ports: clk, reset
// (async, active-high), bus (ps_decoder_if.slave) with lines in, codes/status out.
// Build option PSDEC_CONFIRM_EN: codes need two matching frames before writing.
module ps_decoder
  import ps_pkg::*;
#(
  parameter int STEP    = PS_STEP,
  parameter int PERIOD  = PS_PERIOD,
  parameter int TOL     = PS_TOL,
  parameter int TIMEOUT = PS_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  ps_decoder_if.slave  bus
);

  code_t f_code, a_code;
  logic  f_vld, a_vld, f_wr, a_wr, f_lost_d, a_lost_d;
  logic  update_q, lost_q;

  ps_channel #(.STEP(STEP), .PERIOD(PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)) u_freq (
    .clk      (clk),
    .reset    (reset),
    .line_i   (bus.PSfreq),
    .code_o   (f_code),
    .valid_o  (f_vld),
    .wr_o     (f_wr),
    .lost_d_o (f_lost_d)
  );

  ps_channel #(.STEP(STEP), .PERIOD(PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)) u_amp (
    .clk      (clk),
    .reset    (reset),
    .line_i   (bus.PSamp),
    .code_o   (a_code),
    .valid_o  (a_vld),
    .wr_o     (a_wr),
    .lost_d_o (a_lost_d)
  );

  // Merged here from next-state so update/lost are true registers aligned
  // with the code registers; simultaneous writes give one update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      update_q <= f_wr | a_wr;
      lost_q   <= f_lost_d | a_lost_d;
    end
  end

  assign bus.freq      = f_code;
  assign bus.amp       = a_code;
  assign bus.freqValid = f_vld;
  assign bus.ampValid  = a_vld;
  assign bus.update    = update_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_ps_decoder.sv
module tb_ps_decoder;
  import ps_pkg::*;

  logic clk = 1'b0;
  logic reset;
  ps_decoder_if bus();

  ps_decoder #(.STEP(16), .PERIOD(256), .TOL(8), .TIMEOUT(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // One frame on both lines (common rise and period) and the outputs
  // expected once the following rise closes it.
  typedef struct {
    int   hf;
    int   ha;
    int   p;
    int   ef;
    int   ea;
    logic eupd;
  } vec_t;

  vec_t tbl[12];
  int   seq_code[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive both lines just after the active edge.
  task automatic tick(input logic f, input logic a);
    @(posedge clk);
    #1;
    bus.PSfreq = f;
    bus.PSamp  = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0);
  endtask

  task automatic check_row(input int r);
    chk($sformatf("row%0d_freq", r), 32'(bus.freq), 32'(tbl[r].ef));
    chk($sformatf("row%0d_amp", r), 32'(bus.amp), 32'(tbl[r].ea));
    chk($sformatf("row%0d_fvld", r), 32'(bus.freqValid), 32'd1);
    chk($sformatf("row%0d_avld", r), 32'(bus.ampValid), 32'd1);
    chk($sformatf("row%0d_upd", r), 32'(bus.update), 32'(tbl[r].eupd));
  endtask

  initial begin
    //            hf   ha   p    freq amp upd
    tbl[0]  = '{  96,  16, 256,  5,   0,  1'b1};
    tbl[1]  = '{  96,  16, 256,  5,   0,  1'b1};
    tbl[2]  = '{  96,  16, 270,  5,   0,  1'b0};  // period too long
    tbl[3]  = '{ 152,  16, 256,  5,   0,  1'b1};  // freq n=10 rejected
    tbl[4]  = '{ 135,  16, 256,  7,   0,  1'b1};  // n=8 -> code 7
    tbl[5]  = '{  32,  48, 256,  1,   2,  1'b1};
    tbl[6]  = '{  64, 128, 256,  3,   7,  1'b1};
    tbl[7]  = '{   7,   8, 256,  3,   0,  1'b1};  // freq n=0 rejected, amp rounds up
    tbl[8]  = '{  40,  23, 264,  2,   0,  1'b1};  // +TOL edge accepted
    tbl[9]  = '{  80,  32, 265,  2,   0,  1'b0};  // just past +TOL
    tbl[10] = '{ 143,  24, 248,  2,   1,  1'b1};  // -TOL edge, freq n=9 rejected
    tbl[11] = '{  96,  16, 256,  5,   0,  1'b1};
    seq_code = '{2, 4, 4, 4};

    // Reset values, then an idle line must never report loss.
    reset = 1'b1;
    bus.PSfreq = 1'b0;
    bus.PSamp  = 1'b0;
    repeat (2) tick(1'b0, 1'b0);
    chk("rst_freq", 32'(bus.freq), 32'd0);
    chk("rst_amp", 32'(bus.amp), 32'd0);
    chk("rst_fvld", 32'(bus.freqValid), 32'd0);
    chk("rst_avld", 32'(bus.ampValid), 32'd0);
    chk("rst_upd", 32'(bus.update), 32'd0);
    chk("rst_lost", 32'(bus.lost), 32'd0);
    reset = 1'b0;
    repeat (1100) tick(1'b0, 1'b0);
    chk("idle_lost", 32'(bus.lost), 32'd0);
    chk("idle_fvld", 32'(bus.freqValid), 32'd0);
    chk("idle_avld", 32'(bus.ampValid), 32'd0);

`ifndef PSDEC_CONFIRM_EN
    // Table of frames; each row is checked 3 cycles after the next rise.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].p; k++) begin
        tick(k < tbl[i].hf, k < tbl[i].ha);
        if (i > 0 && k == 2) chk("upd_early", 32'(bus.update), 32'd0);
        if (k == 3) begin
          if (i == 0) chk("open_fvld", 32'(bus.freqValid), 32'd0);
          else        check_row(i - 1);
        end
        if (i > 0 && k == 4) chk("upd_late", 32'(bus.update), 32'd0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1);
      if (k == 3) check_row(11);
    end
`endif

    // Code sequence 2,4,4: immediate vs confirmed write.
    do_reset();
    for (int k = 0; k < 780; k++) begin
      tick((k % 256) < (seq_code[k / 256] + 1) * 16, 1'b0);
`ifdef PSDEC_CONFIRM_EN
      if (k == 259) begin
        chk("cf1_freq", 32'(bus.freq), 32'd0);
        chk("cf1_upd", 32'(bus.update), 32'd0);
      end
      if (k == 515) begin
        chk("cf2_freq", 32'(bus.freq), 32'd0);
        chk("cf2_fvld", 32'(bus.freqValid), 32'd0);
      end
      if (k == 771) begin
        chk("cf3_freq", 32'(bus.freq), 32'd4);
        chk("cf3_upd", 32'(bus.update), 32'd1);
      end
`else
      if (k == 259) begin
        chk("cf1_freq", 32'(bus.freq), 32'd2);
        chk("cf1_upd", 32'(bus.update), 32'd1);
      end
      if (k == 515) begin
        chk("cf2_freq", 32'(bus.freq), 32'd4);
        chk("cf2_upd", 32'(bus.update), 32'd1);
      end
      if (k == 771) begin
        chk("cf3_freq", 32'(bus.freq), 32'd4);
        chk("cf3_upd", 32'(bus.update), 32'd1);
      end
`endif
    end

    // Loss of PSamp (last rise at k=512) and recovery from k=1600.
    do_reset();
    for (int k = 0; k < 2120; k++) begin
      tick((k % 256) < 96,
           (k < 768 && (k % 256) < 64) || (k >= 1600 && ((k - 1600) % 256) < 64));
      if (k == 1539) begin
        chk("loss_pre_lost", 32'(bus.lost), 32'd0);
        chk("loss_pre_avld", 32'(bus.ampValid), 32'd1);
        chk("loss_pre_amp", 32'(bus.amp), 32'd3);
      end
      if (k == 1540) begin
        chk("loss_lost", 32'(bus.lost), 32'd1);
        chk("loss_avld", 32'(bus.ampValid), 32'd0);
        chk("loss_fvld", 32'(bus.freqValid), 32'd1);
      end
      if (k == 1858) chk("rec_pre_lost", 32'(bus.lost), 32'd1);
      if (k == 1859) begin
        chk("rec_lost", 32'(bus.lost), 32'd0);
`ifdef PSDEC_CONFIRM_EN
        chk("rec_avld", 32'(bus.ampValid), 32'd0);
`else
        chk("rec_avld", 32'(bus.ampValid), 32'd1);
`endif
      end
      if (k == 2115) begin
        chk("rec2_avld", 32'(bus.ampValid), 32'd1);
        chk("rec2_amp", 32'(bus.amp), 32'd3);
        chk("rec2_lost", 32'(bus.lost), 32'd0);
      end
    end

    // Reset in the middle of a HIGH phase with freq=5.
    do_reset();
    for (int k = 0; k < 1290; k++) begin
      tick((k % 256) < 96, 1'b0);
      if (k == 529) chk("mid_pre_freq", 32'(bus.freq), 32'd5);
      if (k == 530) begin
        reset = 1'b1;
        #1;
        chk("mid_rst_freq", 32'(bus.freq), 32'd0);
        chk("mid_rst_fvld", 32'(bus.freqValid), 32'd0);
      end
      if (k == 533) reset = 1'b0;
      if (k == 771) begin
        chk("mid_part_freq", 32'(bus.freq), 32'd0);
        chk("mid_part_fvld", 32'(bus.freqValid), 32'd0);
        chk("mid_part_upd", 32'(bus.update), 32'd0);
      end
      if (k == 1027) begin
`ifdef PSDEC_CONFIRM_EN
        chk("mid_res_freq", 32'(bus.freq), 32'd0);
        chk("mid_res_fvld", 32'(bus.freqValid), 32'd0);
`else
        chk("mid_res_freq", 32'(bus.freq), 32'd5);
        chk("mid_res_fvld", 32'(bus.freqValid), 32'd1);
        chk("mid_res_upd", 32'(bus.update), 32'd1);
`endif
      end
      if (k == 1283) begin
        chk("mid_res2_freq", 32'(bus.freq), 32'd5);
        chk("mid_res2_lost", 32'(bus.lost), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ps_decoder.md
# ps_decoder

Power-supply-side decoder for the two pulse-encoded control lines `PSfreq` and `PSamp` driven by the rocking controller's output stage. Each line carries a repeating frame whose high time encodes a 3-bit code. The block recovers the `freq` and `amp` codes, validates frame timing, and flags loss of signal. It sits on the supply/motor board and also serves as the loop-back checker for the controller's output path.

## Interface

Parameters:
- `STEP`, 16: clocks per code unit of high time.
- `PERIOD`, 256: nominal frame length in clocks, rising edge to rising edge. Must be ≥ 9*STEP.
- `TOL`, 8: accepted ± deviation of the measured period.
- `TIMEOUT`, 1024: clocks without a rising edge before the channel is declared lost.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `PSfreq`  in  1  frequency pulse line; asynchronous to `clk`.
- `PSamp`  in  1  amplitude pulse line; asynchronous to `clk`.
- `freq`  out  3  last accepted frequency code.
- `amp`  out  3  last accepted amplitude code.
- `freqValid`  out  1  `freq` holds a code from an accepted frame since the last loss or reset.
- `ampValid`  out  1  same, for `amp`.
- `update`  out  1  one-cycle pulse whenever either code register is written.
- `lost`  out  1  high while either channel is timed out; low otherwise.

## Operation

- **Encoding:**
  - Frame starts on a rising edge.
  - High time H = (code+1)*STEP clocks.
  - Period = PERIOD clocks, so code 0 still produces a rising edge.
- **Synchronization:** each input passes a 2-flop synchronizer. Edge detection runs on the synchronized signal.
- **Per-channel FSM:**
  - IDLE: wait for a rising edge, then → HIGH. Clear H and P.
  - HIGH: increment H and P each cycle. On a falling edge → LOW.
  - LOW: increment P. On a rising edge, evaluate the frame, clear H and P, and return to HIGH.
- **Evaluation:**
  - n = (H + STEP/2) / STEP using integer division.
  - The frame is accepted if 1 ≤ n ≤ 8 and |P − PERIOD| ≤ TOL.
  - If accepted, write code = n−1, set valid, and pulse `update`.
  - If rejected, hold code and valid unchanged. This is a frame error; there is no output for it.
- **Counters:** 16 bits, saturating at all-ones, never wrapping. A saturated H or P always fails evaluation.
- **Timeout:**
  - An independent since-rise counter is cleared on every rising edge.
  - When it reaches TIMEOUT: clear valid, go to IDLE, and assert that channel's lost flag.
  - The lost flag clears on the next accepted frame.
- **Simultaneous events:**
  - A rising edge in the same cycle the timeout would fire takes priority: evaluate, and no loss is declared.
  - Both channels updating in the same cycle produce a single `update` pulse.
- **Reset (including mid-frame):**
  - `freq`, `amp` = 0.
  - Valid flags, `update` = 0.
  - `lost` = 0.
  - FSMs in IDLE, all counters 0.
  - A partial frame in progress at reset is discarded.

## Timing

- Line edge to edge-detect: 2 cycles (synchronizer).
- Code, valid and `update` change 1 cycle after the detected rising edge that closes the frame. Total: frame-closing line edge + 3 cycles.
- First valid code requires two rising edges after reset or loss, because the first edge only opens a frame.
- `lost` asserts 1 cycle after the since-rise counter reaches TIMEOUT.
- All outputs are registered.

## Configuration

- **`PSDEC_CONFIRM_EN` defined:** a code is written only when two consecutive accepted frames decode the same n.
  - A differing or rejected frame restarts confirmation.
  - The first valid code after reset or loss needs three rising edges.
  - Latency is otherwise unchanged, measured from the confirming frame.
- **Not defined:** every accepted frame is written immediately.

## Structure

- **Shared package `ps_pkg`:**
  - FSM state typedef (IDLE/HIGH/LOW).
  - Code width (3).
  - Counter width (16).
  - Default STEP/PERIOD/TOL/TIMEOUT constants, also used by the controller's output stage.
- **Sub-module `ps_channel`:** synchronizer, FSM, counters, evaluation and timeout for one line, instantiated twice.
- **Top:** merges the two `update` pulses and ORs the two lost flags.

## Test plan

All scenarios use STEP=16, PERIOD=256, TOL=8, TIMEOUT=1024.

- **Reset values:** drive `reset` → all outputs 0. Release with lines low for 1100 cycles → `lost` stays 0 and valid stays 0 (no edge ever seen).
- **Basic decode:** `PSfreq` frames with H=96, P=256 (code 5); `PSamp` H=16 (code 0) → after the second rising edge, `freq`=5, `amp`=0, valid high, `update` pulse exactly 3 cycles after the line edge.
- **Frame rejection:**
  - P=270 → `freq` holds its previous value.
  - H=152 (n=10) → rejected.
  - H=135 (n=8) → accepted, `freq`=7.
- **Loss and recovery:** stop `PSamp` toggling → `lost`=1 and `ampValid`=0 at 1024 cycles after the last rise. Resume code-3 frames → `lost` clears on the first accepted frame.
- **Reset mid-operation:** assert `reset` mid-HIGH with `freq`=5 → `freq`=0 immediately. After release, the partial frame is ignored and decode resumes cleanly.
- **Confirmation (`PSDEC_CONFIRM_EN`):** sequence 2,4,4 → `freq` updates to 4 only on the third frame. With the macro off, it updates on every frame.
